oq_status_eval_hyst: RTL
========================

// Module: oq_status_eval_hyst
// PURPOSE
//  Per-queue full/empty status evaluator for the output-queue block, one generation past the
//  single-threshold full flag. Store-side and remove-side updates are evaluated in the same cycle.
//  Word-based full has programmable hysteresis. Adds per-queue empty and a full-assertion event
//  strobe. Sits between the OQ register file and the input arbiter / output scheduler.
// PARAMETERS
//  NUM_QUEUES    8       number of output queues
//  QID_WIDTH     log2(NUM_QUEUES)  queue index width (derived)
//  WORDS_WIDTH   19      width of words-left / threshold fields (SRAM address width)
//  PKTS_WIDTH    16      width of packet-count fields
//  MAX_PKT_WORDS 256     words in a max-size packet; hard headroom = 2*MAX_PKT_WORDS
//  HYST_WORDS    64      words above threshold/headroom required before word-full clears
//  STAT_WIDTH    16      saturating full-event counter width (OQ_EVAL_STATS_EN only)
// PORTS
//  clk              in   1            clock
//  reset            in   1            synchronous, active-high
//  st_update        in   1            store-side snapshot valid (counts after the store)
//  st_oq            in   QID_WIDTH    store-side queue
//  st_num_pkts      in   PKTS_WIDTH   packets in queue
//  st_max_pkts      in   PKTS_WIDTH   packet limit; 0 = unlimited
//  st_words_left    in   WORDS_WIDTH  free words in queue
//  st_full_thresh   in   WORDS_WIDTH  word-full threshold
//  rm_update / rm_oq / rm_num_pkts / rm_max_pkts / rm_words_left / rm_full_thresh
//                   in   (as st_*)    remove-side snapshot (counts after the remove)
//  initialize       in   1            clear status of initialize_oq
//  initialize_oq    in   QID_WIDTH    queue to clear
//  full             out  NUM_QUEUES   registered; pkt_full | word_full per queue
//  empty            out  NUM_QUEUES   registered; num_pkts == 0 per queue
//  full_event       out  1            1-cycle pulse when any full bit rises 0->1
//  full_event_oq    out  QID_WIDTH    lowest-index queue that rose in that cycle
//  stat_rd_en / stat_rd_oq  in  1 / QID_WIDTH     (OQ_EVAL_STATS_EN only) counter read request
//  stat_rd_data     out  STAT_WIDTH   (OQ_EVAL_STATS_EN only) counter value
// BEHAVIOUR
//  - Reset: full=0, empty=all 1s, word_full state=0, full_event=0, full_event_oq=0, counters=0.
//  - Latency: update at cycle N -> full/empty updated at N+1. No backpressure; every update is
//    accepted.
//  - pkt_full  = (max_pkts != 0) && (num_pkts >= max_pkts).
//  - word_full set   : words_left <= full_thresh || words_left < 2*MAX_PKT_WORDS.
//  - word_full clear : words_left > full_thresh+HYST_WORDS && words_left >= 2*MAX_PKT_WORDS+HYST_WORDS.
//  - word_full otherwise holds its prior per-queue value. Sums use WORDS_WIDTH+2 bits; no wrap.
//  - st/rm on different queues: both applied in the same cycle.
//  - st/rm on the same queue: conservative merge.
//      full = OR of the two results; empty = AND of the two results;
//      word_full = OR of the two next-states, each computed from the prior state.
//  - initialize: lowest priority, per queue. Clears full, word_full and empty(->1) of
//    initialize_oq unless st or rm targets that queue in the same cycle; then it is ignored.
//  - full_event: asserted at N+1 when any full bit goes 0->1 at N+1. With multiple rising
//    queues, reports the lowest index; no queuing.
//  - reset mid-operation: all state returns to reset values next cycle; in-flight updates dropped.
// CONFIGURATION
//  - OQ_EVAL_STATS_EN defined: per-queue STAT_WIDTH saturating counter, +1 on each full 0->1
//    rise, cleared by initialize or reset. stat_rd_en at N -> stat_rd_data valid at N+1.
//    A count and a read in the same cycle return the pre-increment value.
//  - Undefined: stat ports absent; stat_rd_data not generated; no counter storage.
// STRUCTURE
//  - Package oq_pkg: QID_WIDTH/WORDS_WIDTH/PKTS_WIDTH constants, log2 function,
//    oq_snapshot_t struct {oq, num_pkts, max_pkts, words_left, full_thresh}.
//  - Sub-module oq_full_calc (combinational): snapshot + prior word_full -> pkt_full,
//    word_full_next, empty. Instantiated twice (st, rm).
// TESTING
//  1. Reset -> full=0x00, empty=0xFF, full_event=0; no stat counter reads nonzero.
//  2. st q3 words_left=600, thresh=600 -> full[3]=1 at N+1, full_event=1, full_event_oq=3.
//  3. rm q3 words_left=640 (thresh 600, HYST 64) -> full[3] stays 1; rm words_left=665 -> full[3]=0.
//  4. st q2 num_pkts=4,max=4 and rm q2 num_pkts=3 same cycle -> full[2]=1, empty[2]=0.
//  5. rm q5 num_pkts=0 and initialize q5 same cycle -> initialize ignored, empty[5]=1 from rm.
//  6. OQ_EVAL_STATS_EN: 3 full rises on q1 -> read q1 returns 3; initialize q1 -> read returns 0.

Source files
------------

// File: rtl/oq_pkg.sv
// Shared constants and the per-side snapshot record for the output-queue status evaluator.
package oq_pkg;

    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    localparam int NUM_QUEUES    = 8;
    localparam int QID_WIDTH     = log2(NUM_QUEUES);
    localparam int WORDS_WIDTH   = 19;
    localparam int PKTS_WIDTH    = 16;
    localparam int MAX_PKT_WORDS = 256;
    localparam int HYST_WORDS    = 64;
    localparam int STAT_WIDTH    = 16;

    typedef struct packed {
        logic [QID_WIDTH-1:0]   oq;
        logic [PKTS_WIDTH-1:0]  num_pkts;
        logic [PKTS_WIDTH-1:0]  max_pkts;
        logic [WORDS_WIDTH-1:0] words_left;
        logic [WORDS_WIDTH-1:0] full_thresh;
    } oq_snapshot_t;

endpackage

// File: rtl/oq_status_eval_hyst_if.sv
// Update/status bundle between the OQ register file, the evaluator and its consumers.
// Stat read signals exist only when OQ_EVAL_STATS_EN is defined.
interface oq_status_eval_hyst_if;
    import oq_pkg::*;

    logic                   st_update;
    logic [QID_WIDTH-1:0]   st_oq;
    logic [PKTS_WIDTH-1:0]  st_num_pkts;
    logic [PKTS_WIDTH-1:0]  st_max_pkts;
    logic [WORDS_WIDTH-1:0] st_words_left;
    logic [WORDS_WIDTH-1:0] st_full_thresh;

    logic                   rm_update;
    logic [QID_WIDTH-1:0]   rm_oq;
    logic [PKTS_WIDTH-1:0]  rm_num_pkts;
    logic [PKTS_WIDTH-1:0]  rm_max_pkts;
    logic [WORDS_WIDTH-1:0] rm_words_left;
    logic [WORDS_WIDTH-1:0] rm_full_thresh;

    logic                   initialize;
    logic [QID_WIDTH-1:0]   initialize_oq;

    logic [NUM_QUEUES-1:0]  full;
    logic [NUM_QUEUES-1:0]  empty;
    logic                   full_event;
    logic [QID_WIDTH-1:0]   full_event_oq;

`ifdef OQ_EVAL_STATS_EN
    logic                   stat_rd_en;
    logic [QID_WIDTH-1:0]   stat_rd_oq;
    logic [STAT_WIDTH-1:0]  stat_rd_data;

    modport master (
        output st_update, st_oq, st_num_pkts, st_max_pkts, st_words_left, st_full_thresh,
        output rm_update, rm_oq, rm_num_pkts, rm_max_pkts, rm_words_left, rm_full_thresh,
        output initialize, initialize_oq, stat_rd_en, stat_rd_oq,
        input  full, empty, full_event, full_event_oq, stat_rd_data
    );
    modport slave (
        input  st_update, st_oq, st_num_pkts, st_max_pkts, st_words_left, st_full_thresh,
        input  rm_update, rm_oq, rm_num_pkts, rm_max_pkts, rm_words_left, rm_full_thresh,
        input  initialize, initialize_oq, stat_rd_en, stat_rd_oq,
        output full, empty, full_event, full_event_oq, stat_rd_data
    );
`else
    modport master (
        output st_update, st_oq, st_num_pkts, st_max_pkts, st_words_left, st_full_thresh,
        output rm_update, rm_oq, rm_num_pkts, rm_max_pkts, rm_words_left, rm_full_thresh,
        output initialize, initialize_oq,
        input  full, empty, full_event, full_event_oq
    );
    modport slave (
        input  st_update, st_oq, st_num_pkts, st_max_pkts, st_words_left, st_full_thresh,
        input  rm_update, rm_oq, rm_num_pkts, rm_max_pkts, rm_words_left, rm_full_thresh,
        input  initialize, initialize_oq,
        output full, empty, full_event, full_event_oq
    );
`endif
endinterface

// File: rtl/oq_status_eval_hyst_full_calc.sv
// Combinational full/empty evaluation of one snapshot, with word-full hysteresis
// against the queue's prior word-full state.
module oq_full_calc
    import oq_pkg::*;
(
    input  logic [PKTS_WIDTH-1:0]  num_pkts_i,
    input  logic [PKTS_WIDTH-1:0]  max_pkts_i,
    input  logic [WORDS_WIDTH-1:0] words_left_i,
    input  logic [WORDS_WIDTH-1:0] full_thresh_i,
    input  logic                   word_full_i,
    output logic                   pkt_full_o,
    output logic                   word_full_next_o,
    output logic                   empty_o
);
    // Two spare bits so thresh+HYST and the headroom sums never wrap.
    localparam int SW = WORDS_WIDTH + 2;
    localparam logic [SW-1:0] HEADROOM = SW'(2 * MAX_PKT_WORDS);
    localparam logic [SW-1:0] HYST     = SW'(HYST_WORDS);

    logic [SW-1:0] wl, th;
    logic          set_wf, clr_wf;

    always_comb begin
        wl     = {2'b00, words_left_i};
        th     = {2'b00, full_thresh_i};
        set_wf = (wl <= th) || (wl < HEADROOM);
        clr_wf = (wl > th + HYST) && (wl >= HEADROOM + HYST);
        word_full_next_o = set_wf ? 1'b1 : (clr_wf ? 1'b0 : word_full_i);
        pkt_full_o = (max_pkts_i != '0) && (num_pkts_i >= max_pkts_i);
        empty_o    = (num_pkts_i == '0);
    end
endmodule

// File: rtl/oq_status_eval_hyst.sv
// Per-queue full/empty status with word-full hysteresis and full-rise event strobe.
// Define OQ_EVAL_STATS_EN to add per-queue saturating full-rise counters with a read port.
module oq_status_eval_hyst
    import oq_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    oq_status_eval_hyst_if.slave  bus
);
    oq_snapshot_t st_snap, rm_snap;
    logic st_pkt_full, st_wf_next, st_empty;
    logic rm_pkt_full, rm_wf_next, rm_empty;

    logic [NUM_QUEUES-1:0] full_q, full_d;
    logic [NUM_QUEUES-1:0] empty_q, empty_d;
    logic [NUM_QUEUES-1:0] wfull_q, wfull_d;
    logic [NUM_QUEUES-1:0] rise, init_eff;
    logic                  ev_q, ev_d;
    logic [QID_WIDTH-1:0]  ev_oq_q, ev_oq_d;

    assign st_snap = '{bus.st_oq, bus.st_num_pkts, bus.st_max_pkts, bus.st_words_left, bus.st_full_thresh};
    assign rm_snap = '{bus.rm_oq, bus.rm_num_pkts, bus.rm_max_pkts, bus.rm_words_left, bus.rm_full_thresh};

    oq_full_calc u_st_calc (
        .num_pkts_i      (st_snap.num_pkts),
        .max_pkts_i      (st_snap.max_pkts),
        .words_left_i    (st_snap.words_left),
        .full_thresh_i   (st_snap.full_thresh),
        .word_full_i     (wfull_q[st_snap.oq]),
        .pkt_full_o      (st_pkt_full),
        .word_full_next_o(st_wf_next),
        .empty_o         (st_empty)
    );

    oq_full_calc u_rm_calc (
        .num_pkts_i      (rm_snap.num_pkts),
        .max_pkts_i      (rm_snap.max_pkts),
        .words_left_i    (rm_snap.words_left),
        .full_thresh_i   (rm_snap.full_thresh),
        .word_full_i     (wfull_q[rm_snap.oq]),
        .pkt_full_o      (rm_pkt_full),
        .word_full_next_o(rm_wf_next),
        .empty_o         (rm_empty)
    );

    always_comb begin
        full_d   = full_q;
        empty_d  = empty_q;
        wfull_d  = wfull_q;
        init_eff = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            logic hit_st, hit_rm;
            hit_st = bus.st_update && (st_snap.oq == QID_WIDTH'(q));
            hit_rm = bus.rm_update && (rm_snap.oq == QID_WIDTH'(q));
            // Same-queue collision merges conservatively: either side can make it full/non-empty.
            if (hit_st && hit_rm) begin
                wfull_d[q] = st_wf_next | rm_wf_next;
                full_d[q]  = st_pkt_full | st_wf_next | rm_pkt_full | rm_wf_next;
                empty_d[q] = st_empty & rm_empty;
            end else if (hit_st) begin
                wfull_d[q] = st_wf_next;
                full_d[q]  = st_pkt_full | st_wf_next;
                empty_d[q] = st_empty;
            end else if (hit_rm) begin
                wfull_d[q] = rm_wf_next;
                full_d[q]  = rm_pkt_full | rm_wf_next;
                empty_d[q] = rm_empty;
            end else if (bus.initialize && (bus.initialize_oq == QID_WIDTH'(q))) begin
                init_eff[q] = 1'b1;
                wfull_d[q]  = 1'b0;
                full_d[q]   = 1'b0;
                empty_d[q]  = 1'b1;
            end
        end
        rise    = full_d & ~full_q;
        ev_d    = |rise;
        ev_oq_d = '0;
        for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
            if (rise[q]) ev_oq_d = QID_WIDTH'(q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= '0;
            empty_q <= '1;
            wfull_q <= '0;
            ev_q    <= 1'b0;
            ev_oq_q <= '0;
        end else begin
            full_q  <= full_d;
            empty_q <= empty_d;
            wfull_q <= wfull_d;
            ev_q    <= ev_d;
            ev_oq_q <= ev_oq_d;
        end
    end

    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.full_event    = ev_q;
    assign bus.full_event_oq = ev_oq_q;

`ifdef OQ_EVAL_STATS_EN
    logic [STAT_WIDTH-1:0] cnt_q [NUM_QUEUES];
    logic [STAT_WIDTH-1:0] rd_data_q;

    // Read samples the current counter, so a same-cycle rise is seen on the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= '0;
            rd_data_q <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (init_eff[q])
                    cnt_q[q] <= '0;
                else if (rise[q] && (cnt_q[q] != '1))
                    cnt_q[q] <= cnt_q[q] + 1'b1;
            end
            if (bus.stat_rd_en) rd_data_q <= cnt_q[bus.stat_rd_oq];
        end
    end

    assign bus.stat_rd_data = rd_data_q;
`endif
endmodule
